// File: rtl/srmem_bank.sv
// Multi-lane shift-register memory: round-robin serial fill, padded partial rows,
// head alignment and optional recirculating replay of the stored rows.
module srmem_bank #(
    parameter int NUM_RDPORT = 2,
    parameter int LEN_SRMEM  = 4,
    parameter int DATA_BW    = 8,
    localparam int CW = $clog2(LEN_SRMEM + 1),
    localparam int PW = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1,
    localparam int EW = DATA_BW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_din,
    input  logic [DATA_BW-1:0]         din,
    input  logic                       is_lastdin,
    input  logic [CW-1:0]              cfg_len,
    input  logic                       cfg_recirc,
    input  logic                       req_pop,
    input  logic                       req_newdata,
    output logic [NUM_RDPORT*EW-1:0]   dout_list,
    output logic                       wrfull,
    output logic                       rdvalid,
    output logic                       wrend,
    output logic                       rdend,
    output logic                       rdnext,
    output logic                       rdlast
);
    typedef enum logic [1:0] {S_FILL, S_ALIGN, S_READ} state_t;

    localparam logic [CW-1:0] LEN_C    = CW'(LEN_SRMEM);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_RDPORT - 1);

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_wrptr;
    logic [CW-1:0]   r_rowcnt, r_rows, r_popcnt, r_len, r_aligncnt;
    logic            r_recirc, r_wrend;

    logic [NUM_RDPORT-1:0] w_head_vld;
    logic [CW-1:0]   w_len_eff, w_rows_close;
    logic            w_accept, w_wrap, w_close, w_pop, w_newdata, w_rotate, w_recirc_end;

    assign w_len_eff    = (cfg_len == '0 || cfg_len > LEN_C) ? LEN_C : cfg_len;
    assign w_rows_close = r_rowcnt + CW'(1);
    assign w_newdata    = req_newdata && (r_state != S_FILL);
    assign w_accept     = (r_state == S_FILL) && valid_din && !wrfull;
    assign w_wrap       = (r_wrptr == PTR_LAST);
    // The fill closes on the marked last word or when the final active row completes.
    assign w_close      = w_accept && (is_lastdin || (w_wrap && w_rows_close == r_len));
    assign w_rotate     = (r_state == S_ALIGN) && !w_newdata;
    assign w_pop        = (r_state == S_READ) && req_pop && rdvalid && !w_newdata;
    assign w_recirc_end = w_pop && rdlast && r_recirc;

    assign wrfull  = (r_state != S_FILL) || (r_rowcnt == r_len);
    assign rdvalid = (r_state == S_READ) && (|w_head_vld);
    assign rdlast  = rdvalid && (r_popcnt == r_rows - CW'(1));
    assign rdnext  = rdvalid && !rdlast;
    assign rdend   = w_pop && rdlast;
    assign wrend   = r_wrend;

    always_comb begin
        w_state_next = r_state;
        if (w_newdata) begin
            w_state_next = S_FILL;
        end else begin
            case (r_state)
                S_FILL:  if (w_close) w_state_next = (w_rows_close < LEN_C) ? S_ALIGN : S_READ;
                S_ALIGN: if (r_aligncnt <= CW'(1)) w_state_next = S_READ;
                S_READ:  if (w_recirc_end) w_state_next = (r_rows < LEN_C) ? S_ALIGN : S_READ;
                default: w_state_next = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrptr    <= '0;
            r_rowcnt   <= '0;
            r_rows     <= '0;
            r_popcnt   <= '0;
            r_len      <= LEN_C;
            r_recirc   <= 1'b0;
            r_aligncnt <= '0;
            r_wrend    <= 1'b0;
        end else begin
            r_wrend <= w_close;
            if (w_newdata) begin
                r_wrptr  <= '0;
                r_rowcnt <= '0;
                r_popcnt <= '0;
                r_len    <= w_len_eff;
                r_recirc <= cfg_recirc;
            end else begin
                if (w_accept) begin
                    r_wrptr <= w_wrap ? '0 : r_wrptr + PW'(1);
                    if (w_wrap) r_rowcnt <= w_rows_close;
                end
                if (w_close) begin
                    r_rows     <= w_rows_close;
                    r_aligncnt <= LEN_C - w_rows_close;
                end
                if (w_rotate) r_aligncnt <= r_aligncnt - CW'(1);
                if (w_recirc_end) begin
                    r_popcnt   <= '0;
                    r_aligncnt <= LEN_C - r_rows;
                end else if (w_pop) begin
                    r_popcnt <= r_popcnt + CW'(1);
                end
            end
        end
    end

    // Each lane is a shift chain: slot 0 is the tail, slot LEN_SRMEM-1 the head.
    for (genvar gi = 0; gi < NUM_RDPORT; gi++) begin : g_lane
        logic [EW-1:0] r_slot [LEN_SRMEM];
        logic          w_lane_wr, w_lane_pad, w_shift;
        logic [EW-1:0] w_shift_in;

        assign w_lane_wr  = w_accept && (r_wrptr == PW'(gi));
        assign w_lane_pad = w_close && is_lastdin && (PW'(gi) > r_wrptr);
        assign w_shift    = w_rotate || w_pop || w_lane_wr || w_lane_pad;
        assign w_shift_in = (w_rotate || (w_pop && r_recirc)) ? r_slot[LEN_SRMEM-1] :
                            (w_lane_wr ? {1'b1, din} : '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < LEN_SRMEM; k++) r_slot[k] <= '0;
            end else if (w_newdata) begin
                for (int k = 0; k < LEN_SRMEM; k++) r_slot[k][EW-1] <= 1'b0;
            end else if (w_shift) begin
                r_slot[0] <= w_shift_in;
                for (int k = 1; k < LEN_SRMEM; k++) r_slot[k] <= r_slot[k-1];
            end
        end

        assign dout_list[gi*EW +: EW] = r_slot[LEN_SRMEM-1];
        assign w_head_vld[gi]         = r_slot[LEN_SRMEM-1][EW-1];
    end
endmodule

// File: tb/tb_srmem_bank.sv
// Directed bench for srmem_bank (2 lanes, 4 rows, 8-bit data) with hand-computed rows.
module tb_srmem_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_din = 1'b0;
    logic [7:0]  din = '0;
    logic        is_lastdin = 1'b0;
    logic [2:0]  cfg_len = '0;
    logic        cfg_recirc = 1'b0;
    logic        req_pop = 1'b0;
    logic        req_newdata = 1'b0;
    logic [17:0] dout_list;
    logic        wrfull, rdvalid, wrend, rdend, rdnext, rdlast;

    int checks = 0;
    int errors = 0;

    localparam logic [17:0] VMASK = 18'h20100;

    srmem_bank #(.NUM_RDPORT(2), .LEN_SRMEM(4), .DATA_BW(8)) dut (
        .clk(clk), .rst(rst), .valid_din(valid_din), .din(din), .is_lastdin(is_lastdin),
        .cfg_len(cfg_len), .cfg_recirc(cfg_recirc), .req_pop(req_pop), .req_newdata(req_newdata),
        .dout_list(dout_list), .wrfull(wrfull), .rdvalid(rdvalid), .wrend(wrend),
        .rdend(rdend), .rdnext(rdnext), .rdlast(rdlast)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] row(input logic v1, input logic [7:0] d1,
                                        input logic v0, input logic [7:0] d0);
        return {v1, d1, v0, d0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        valid_din = 1'b1; din = d; is_lastdin = last;
        tick();
        valid_din = 1'b0; is_lastdin = 1'b0;
        $display("write din=%02h last=%0d wrfull=%0d", d, last, wrfull);
    endtask

    task automatic pop(input string tag, input logic exp_rdend);
        req_pop = 1'b1;
        #1;
        chk({tag, "_rdend"}, 32'(rdend), 32'(exp_rdend));
        tick();
        req_pop = 1'b0;
        #1;
        $display("pop %s head=%05h rdvalid=%0d rdlast=%0d", tag, dout_list, rdvalid, rdlast);
    endtask

    task automatic newdata(input logic [2:0] len, input logic recirc);
        req_newdata = 1'b1; cfg_len = len; cfg_recirc = recirc;
        tick();
        req_newdata = 1'b0;
        $display("newdata len=%0d recirc=%0d", len, recirc);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout_list), 0);
        chk("rst_flags", {26'd0, wrfull, rdvalid, wrend, rdend, rdnext, rdlast}, 0);
        rst = 1'b0;
        #1;

        // Full fill, no alignment needed.
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7);
        chk("full_wrfull", 32'(wrfull), 1);
        chk("full_wrend", 32'(wrend), 1);
        chk("full_rdvalid", 32'(rdvalid), 1);
        chk("full_head0", 32'(dout_list), 32'(row(1, 8'h11, 1, 8'h10)));
        chk("full_rdnext", 32'(rdnext), 1);
        pop("full_p1", 1'b0);
        chk("full_wrend_low", 32'(wrend), 0);
        chk("full_head1", 32'(dout_list), 32'(row(1, 8'h13, 1, 8'h12)));
        pop("full_p2", 1'b0);
        chk("full_head2", 32'(dout_list), 32'(row(1, 8'h15, 1, 8'h14)));
        pop("full_p3", 1'b0);
        chk("full_head3", 32'(dout_list), 32'(row(1, 8'h17, 1, 8'h16)));
        chk("full_rdlast", {30'd0, rdnext, rdlast}, 1);
        pop("full_p4", 1'b1);
        chk("full_done", {30'd0, rdvalid, rdlast}, 0);
        pop("full_p5_ign", 1'b0);

        // Partial fill: lane 1 padded, two alignment cycles.
        newdata(3'd0, 1'b0);
        chk("nd_wrfull", 32'(wrfull), 0);
        send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        chk("part_wrend", 32'(wrend), 1);
        chk("part_align0", {30'd0, wrfull, rdvalid}, 2);
        tick();
        chk("part_align1", 32'(rdvalid), 0);
        pop("part_pop_in_align", 1'b0);
        chk("part_head0", 32'(dout_list), 32'(row(1, 8'hA1, 1, 8'hA0)));
        chk("part_rdvalid", {29'd0, rdvalid, rdnext, rdlast}, 6);
        pop("part_p1", 1'b0);
        chk("part_head1", 32'(dout_list), 32'(row(0, 8'h00, 1, 8'hA2)));
        chk("part_rdlast", 32'(rdlast), 1);
        pop("part_p2", 1'b1);
        chk("part_done", 32'(rdvalid), 0);

        // Recirculating replay over three passes.
        newdata(3'd0, 1'b1);
        send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        tick(); tick();
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("rc%0d_head0", p), 32'(dout_list), 32'(row(1, 8'hA1, 1, 8'hA0)));
            chk($sformatf("rc%0d_rdnext", p), 32'(rdnext), 1);
            pop($sformatf("rc%0d_p1", p), 1'b0);
            chk($sformatf("rc%0d_head1", p), 32'(dout_list), 32'(row(0, 8'h00, 1, 8'hA2)));
            chk($sformatf("rc%0d_rdlast", p), 32'(rdlast), 1);
            pop($sformatf("rc%0d_p2", p), 1'b1);
            chk($sformatf("rc%0d_align", p), 32'(rdvalid), 0);
            tick();
            chk($sformatf("rc%0d_align2", p), 32'(rdvalid), 0);
            tick();
        end

        // Runtime length of two rows; surplus words are ignored.
        newdata(3'd2, 1'b0);
        send(8'hB0, 1'b0); send(8'hB1, 1'b0); send(8'hB2, 1'b0);
        chk("len2_notfull", 32'(wrfull), 0);
        send(8'hB3, 1'b0);
        chk("len2_full", {30'd0, wrfull, wrend}, 3);
        send(8'hB4, 1'b0); send(8'hB5, 1'b0);
        chk("len2_head0", 32'(dout_list), 32'(row(1, 8'hB1, 1, 8'hB0)));
        chk("len2_rdvalid", 32'(rdvalid), 1);
        pop("len2_p1", 1'b0);
        chk("len2_head1", 32'(dout_list), 32'(row(1, 8'hB3, 1, 8'hB2)));
        chk("len2_rdlast", 32'(rdlast), 1);
        pop("len2_p2", 1'b1);
        chk("len2_done", 32'(rdvalid), 0);

        // newdata beats a simultaneous pop.
        newdata(3'd0, 1'b0);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), i == 7);
        chk("nd_pre_head", 32'(dout_list), 32'(row(1, 8'hC1, 1, 8'hC0)));
        req_pop = 1'b1; req_newdata = 1'b1;
        #1;
        chk("nd_pop_rdend", 32'(rdend), 0);
        tick();
        req_pop = 1'b0; req_newdata = 1'b0;
        #1;
        chk("nd_pop_state", {30'd0, wrfull, rdvalid}, 0);
        chk("nd_pop_valid", 32'(dout_list & VMASK), 0);

        // Asynchronous reset in the middle of ALIGN.
        send(8'hD0, 1'b0); send(8'hD1, 1'b0); send(8'hD2, 1'b1);
        chk("ar_pre", 32'(wrfull), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_dout", 32'(dout_list), 0);
        chk("ar_flags", {26'd0, wrfull, rdvalid, wrend, rdend, rdnext, rdlast}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7);
        chk("ar_head0", 32'(dout_list), 32'(row(1, 8'h11, 1, 8'h10)));
        chk("ar_wrend", {30'd0, wrend, rdvalid}, 3);
        pop("ar_p1", 1'b0);
        chk("ar_head1", 32'(dout_list), 32'(row(1, 8'h13, 1, 8'h12)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
